// File: rtl/cpu_datapath_pkg.sv
// Shared constants for the single-bus datapath: widths, ALU opcodes and bus source codes.
package cpu_datapath_pkg;

    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 16;

    localparam logic [4:0] OP_ADD  = 5'b00001;
    localparam logic [4:0] OP_ADDI = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01100;
    localparam logic [4:0] OP_DIV  = 5'b01101;
    localparam logic [4:0] OP_NEG  = 5'b01110;
    localparam logic [4:0] OP_NOT  = 5'b01111;

    // Codes 0-15 name the general registers directly.
    localparam logic [4:0] BUS_ZHI  = 5'd16;
    localparam logic [4:0] BUS_ZLO  = 5'd17;
    localparam logic [4:0] BUS_PC   = 5'd18;
    localparam logic [4:0] BUS_MDR  = 5'd19;
    localparam logic [4:0] BUS_C    = 5'd20;
    localparam logic [4:0] BUS_NONE = 5'd31;

    function automatic logic [DATA_W-1:0] sign_ext_c(input logic [DATA_W-1:0] ir);
        return {{13{ir[18]}}, ir[18:0]};
    endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU: A comes from Y, B from the bus; 64-bit result feeds {Z_HI, Z_LO}.
module cpu_alu
    import cpu_datapath_pkg::*;
(
    input  logic [4:0]          op,
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    output logic [2*DATA_W-1:0] result
);

    logic [4:0]          sh;
    logic signed [63:0]  prod;
    logic signed [32:0]  a33, b33, q33, r33;

    assign sh   = b[4:0];
    assign prod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    // 33-bit operands keep -2^31 / -1 from overflowing before truncation.
    assign a33  = $signed({a[31], a});
    assign b33  = $signed({b[31], b});

    always_comb begin
        result = '0;
        q33    = '0;
        r33    = '0;
        case (op)
            OP_ADD, OP_ADDI: result = {32'h0, a + b};
            OP_SUB:  result = {32'h0, a - b};
            OP_AND:  result = {32'h0, a & b};
            OP_OR:   result = {32'h0, a | b};
            OP_SHR:  result = {32'h0, a >> sh};
            OP_SHRA: result = {32'h0, $unsigned($signed(a) >>> sh)};
            OP_SHL:  result = {32'h0, a << sh};
            OP_ROR:  result = {32'h0, (a >> sh) | (a << (6'd32 - {1'b0, sh}))};
            OP_ROL:  result = {32'h0, (a << sh) | (a >> (6'd32 - {1'b0, sh}))};
            OP_MUL:  result = $unsigned(prod);
            OP_DIV: begin
                if (b != '0) begin
                    q33    = a33 / b33;
                    r33    = a33 % b33;
                    result = {r33[31:0], q33[31:0]};
                end
            end
            OP_NEG:  result = {32'h0, 32'h0 - b};
            OP_NOT:  result = {32'h0, ~b};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/cpu_datapath.sv
// Mini-SRC single-bus datapath with register file, ALU and RAM.
module cpu_datapath
    import cpu_datapath_pkg::*;
#(
    parameter int    MEM_DEPTH = 512,
    parameter string MEM_FILE  = "ram_init.hex"
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              PC_enable,
    input  logic              PC_increment_enable,
    input  logic              IR_enable,
    input  logic              Y_enable,
    input  logic              Z_enable,
    input  logic              MAR_enable,
    input  logic              MDR_enable,
    input  logic              r_enable,
    input  logic              read,
    input  logic              write,
    input  logic              Gra,
    input  logic              Grb,
    input  logic              BAout,
    input  logic              PC_select,
    input  logic              Z_LO_select,
    input  logic              MDR_select,
    input  logic              c_select,
    input  logic              r_select,
    input  logic [4:0]        alu_instruction,
    output logic [4:0]        bus_select,
    output logic [15:0]       generalRegSelect,
    output logic [DATA_W-1:0] bus_Data,
    output logic [DATA_W-1:0] R2_Data,
    output logic [DATA_W-1:0] R3_Data,
    output logic [DATA_W-1:0] PC_Data,
    output logic [DATA_W-1:0] IR_Data,
    output logic [DATA_W-1:0] Y_Data,
    output logic [DATA_W-1:0] Z_HI_Data,
    output logic [DATA_W-1:0] Z_LO_Data,
    output logic [DATA_W-1:0] MAR_Data,
    output logic [DATA_W-1:0] MDR_Data,
    output logic [DATA_W-1:0] MDataIN
);

    localparam int AW = $clog2(MEM_DEPTH);

    logic [NUM_REGS-1:0][DATA_W-1:0] regs;
    logic [DATA_W-1:0]   pc, ir, y, z_hi, z_lo, mar, mdr;
    logic [2*DATA_W-1:0] alu_result;
    logic [3:0]          reg_idx;
    logic                reg_drive;

    logic [DATA_W-1:0] ram [MEM_DEPTH] = '{default: '0};

    // Select-and-encode: Gra takes precedence over Grb.
    assign reg_idx   = Gra ? ir[26:23] : ir[22:19];
    assign reg_drive = (r_select || BAout) && (Gra || Grb);

    always_comb begin
        generalRegSelect = '0;
        if (Gra || Grb)
            generalRegSelect[reg_idx] = 1'b1;
    end

    always_comb begin
        bus_select = BUS_NONE;
        bus_Data   = '0;
        if (reg_drive) begin
            bus_select = {1'b0, reg_idx};
            bus_Data   = (BAout && reg_idx == 4'd0) ? '0 : regs[reg_idx];
        end else if (Z_LO_select) begin
            bus_select = BUS_ZLO;
            bus_Data   = z_lo;
        end else if (PC_select) begin
            bus_select = BUS_PC;
            bus_Data   = pc;
        end else if (MDR_select) begin
            bus_select = BUS_MDR;
            bus_Data   = mdr;
        end else if (c_select) begin
            bus_select = BUS_C;
            bus_Data   = sign_ext_c(ir);
        end
    end

    assign MDataIN = read ? ram[mar[AW-1:0]] : bus_Data;

    cpu_alu u_alu (
        .op     (alu_instruction),
        .a      (y),
        .b      (bus_Data),
        .result (alu_result)
    );

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            regs <= '0;
        end else if (r_enable) begin
            for (int i = 0; i < NUM_REGS; i++)
                if (generalRegSelect[i])
                    regs[i] <= bus_Data;
        end
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            pc   <= '0;
            ir   <= '0;
            y    <= '0;
            z_hi <= '0;
            z_lo <= '0;
            mar  <= '0;
            mdr  <= '0;
        end else begin
            if (PC_enable)                pc <= bus_Data;
            else if (PC_increment_enable) pc <= pc + 32'd1;
            if (IR_enable)  ir  <= bus_Data;
            if (Y_enable)   y   <= bus_Data;
            if (MAR_enable) mar <= bus_Data;
            if (MDR_enable) mdr <= MDataIN;
            if (Z_enable)   {z_hi, z_lo} <= alu_result;
        end
    end

    // RAM contents survive clear; writes take the pre-edge MDR.
    always_ff @(posedge clk) begin
        if (write)
            ram[mar[AW-1:0]] <= mdr;
    end

    assign R2_Data   = regs[2];
    assign R3_Data   = regs[3];
    assign PC_Data   = pc;
    assign IR_Data   = ir;
    assign Y_Data    = y;
    assign Z_HI_Data = z_hi;
    assign Z_LO_Data = z_lo;
    assign MAR_Data  = mar;
    assign MDR_Data  = mdr;

endmodule

// File: tb/tb_cpu_datapath.sv
// Directed Mini-SRC T-state sequences plus random control traffic, checked against a behavioural model.
module tb_cpu_datapath;

    logic clk = 1'b0;
    logic clear;
    logic PC_enable, PC_increment_enable, IR_enable, Y_enable, Z_enable;
    logic MAR_enable, MDR_enable, r_enable, read, write, Gra, Grb, BAout;
    logic PC_select, Z_LO_select, MDR_select, c_select, r_select;
    logic [4:0]  alu_instruction;
    logic [4:0]  bus_select;
    logic [15:0] generalRegSelect;
    logic [31:0] bus_Data, R2_Data, R3_Data, PC_Data, IR_Data, Y_Data;
    logic [31:0] Z_HI_Data, Z_LO_Data, MAR_Data, MDR_Data, MDataIN;

    cpu_datapath dut (
        .clk(clk), .clear(clear),
        .PC_enable(PC_enable), .PC_increment_enable(PC_increment_enable),
        .IR_enable(IR_enable), .Y_enable(Y_enable), .Z_enable(Z_enable),
        .MAR_enable(MAR_enable), .MDR_enable(MDR_enable), .r_enable(r_enable),
        .read(read), .write(write), .Gra(Gra), .Grb(Grb), .BAout(BAout),
        .PC_select(PC_select), .Z_LO_select(Z_LO_select), .MDR_select(MDR_select),
        .c_select(c_select), .r_select(r_select), .alu_instruction(alu_instruction),
        .bus_select(bus_select), .generalRegSelect(generalRegSelect), .bus_Data(bus_Data),
        .R2_Data(R2_Data), .R3_Data(R3_Data), .PC_Data(PC_Data), .IR_Data(IR_Data),
        .Y_Data(Y_Data), .Z_HI_Data(Z_HI_Data), .Z_LO_Data(Z_LO_Data),
        .MAR_Data(MAR_Data), .MDR_Data(MDR_Data), .MDataIN(MDataIN)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Architectural state of the reference model.
    logic [31:0] m_r [16];
    logic [31:0] m_mem [512];
    logic [31:0] m_pc, m_ir, m_y, m_zhi, m_zlo, m_mar, m_mdr;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < 16; i++) m_r[i] = '0;
        {m_pc, m_ir, m_y, m_zhi, m_zlo, m_mar, m_mdr} = '0;
    endtask

    function automatic logic [63:0] m_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic signed [31:0] as32;
        logic [63:0] t;
        int sh;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        as32 = a;
        sh = int'(b[4:0]);
        case (op)
            5'd1, 5'd3: return {32'h0, a + b};
            5'd4:  return {32'h0, a - b};
            5'd5:  return {32'h0, a & b};
            5'd6:  return {32'h0, a | b};
            5'd7:  return {32'h0, a >> sh};
            5'd8:  return {32'h0, 32'(as32 >>> sh)};
            5'd9:  return {32'h0, a << sh};
            5'd10: begin t = {a, a} >> sh; return {32'h0, t[31:0]}; end
            5'd11: begin t = {a, a} << sh; return {32'h0, t[63:32]}; end
            5'd12: return 64'(sa * sb);
            5'd13: begin
                if (b == 0) return 64'h0;
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            5'd14: return {32'h0, -b};
            5'd15: return {32'h0, ~b};
            default: return 64'h0;
        endcase
    endfunction

    task automatic m_bus(output logic [4:0] code, output logic [31:0] data);
        logic [3:0] s;
        s = Gra ? m_ir[26:23] : m_ir[22:19];
        if ((r_select || BAout) && (Gra || Grb)) begin
            code = {1'b0, s};
            data = (BAout && s == 4'd0) ? 32'h0 : m_r[s];
        end else if (Z_LO_select) begin code = 5'd17; data = m_zlo; end
        else if (PC_select)       begin code = 5'd18; data = m_pc;  end
        else if (MDR_select)      begin code = 5'd19; data = m_mdr; end
        else if (c_select)        begin code = 5'd20; data = {{13{m_ir[18]}}, m_ir[18:0]}; end
        else                      begin code = 5'd31; data = 32'h0; end
    endtask

    task automatic idle();
        {PC_enable, PC_increment_enable, IR_enable, Y_enable, Z_enable} = '0;
        {MAR_enable, MDR_enable, r_enable, read, write, Gra, Grb, BAout} = '0;
        {PC_select, Z_LO_select, MDR_select, c_select, r_select} = '0;
        alu_instruction = '0;
    endtask

    task automatic chk_regs();
        chk("R2", R2_Data, m_r[2]);
        chk("R3", R3_Data, m_r[3]);
        chk("PC", PC_Data, m_pc);
        chk("IR", IR_Data, m_ir);
        chk("Y", Y_Data, m_y);
        chk("ZHI", Z_HI_Data, m_zhi);
        chk("ZLO", Z_LO_Data, m_zlo);
        chk("MAR", MAR_Data, m_mar);
        chk("MDR", MDR_Data, m_mdr);
    endtask

    // One T-state: check combinational outputs, clock, advance the model, check registers.
    task automatic tick();
        logic [4:0]  code;
        logic [31:0] data, mdin;
        logic [63:0] z;
        logic [3:0]  s;
        logic [15:0] gsel;
        #1;
        m_bus(code, data);
        s = Gra ? m_ir[26:23] : m_ir[22:19];
        gsel = (Gra || Grb) ? (16'h1 << s) : 16'h0;
        mdin = read ? m_mem[m_mar[8:0]] : data;
        chk("bus_select", bus_select, code);
        chk("bus_Data", bus_Data, data);
        chk("genRegSel", generalRegSelect, gsel);
        chk("MDataIN", MDataIN, mdin);
        z = m_alu(alu_instruction, m_y, data);
        @(posedge clk);
        if (write) m_mem[m_mar[8:0]] = m_mdr;
        if (r_enable && (Gra || Grb)) m_r[s] = data;
        if (PC_enable) m_pc = data;
        else if (PC_increment_enable) m_pc = m_pc + 1;
        if (IR_enable)  m_ir = data;
        if (Y_enable)   m_y = data;
        if (MAR_enable) m_mar = data;
        if (MDR_enable) m_mdr = mdin;
        if (Z_enable)   {m_zhi, m_zlo} = z;
        #1;
        chk_regs();
    endtask

    task automatic do_clear();
        idle();
        clear = 1'b1;
        #1;
        m_reset();
        chk_regs();
        chk("clr_bus_select", bus_select, 5'd31);
        chk("clr_bus_Data", bus_Data, 32'h0);
        clear = 1'b0;
    endtask

    // Builds v in R0 by doubling and adding one; assumes IR's rb field is 0.
    task automatic load_const(input logic [31:0] v);
        idle(); Grb = 1; r_enable = 1; tick();
        for (int b = 31; b >= 0; b--) begin
            idle(); Grb = 1; r_select = 1; Y_enable = 1; tick();
            idle(); Grb = 1; r_select = 1; alu_instruction = 5'd1; Z_enable = 1; tick();
            idle(); Grb = 1; Z_LO_select = 1; r_enable = 1; tick();
            if (v[b]) begin
                idle(); Grb = 1; r_select = 1; alu_instruction = 5'd15; Z_enable = 1; tick();
                idle(); Grb = 1; Z_LO_select = 1; r_enable = 1; tick();
                idle(); Grb = 1; r_select = 1; alu_instruction = 5'd14; Z_enable = 1; tick();
                idle(); Grb = 1; Z_LO_select = 1; r_enable = 1; tick();
            end
        end
        idle();
    endtask

    task automatic fetch();
        idle(); PC_select = 1; MAR_enable = 1; tick();
        idle(); PC_increment_enable = 1; read = 1; MDR_enable = 1; tick();
        idle(); MDR_select = 1; IR_enable = 1; tick();
    endtask

    task automatic r0_to_mdr();
        idle(); Grb = 1; r_select = 1; MDR_enable = 1; tick();
    endtask

    initial begin
        for (int i = 0; i < 512; i++) m_mem[i] = '0;
        idle();
        clear = 1'b0;
        do_clear();

        // Place the two test instructions in RAM[0] and RAM[1].
        load_const(32'h09800065);
        r0_to_mdr();
        idle(); MAR_enable = 1; tick();
        idle(); write = 1; tick();
        load_const(32'h611FFFFB);
        r0_to_mdr();
        idle(); PC_increment_enable = 1; tick();
        idle(); PC_select = 1; MAR_enable = 1; tick();
        idle(); write = 1; tick();

        do_clear();

        // ldi R3, 0x65
        fetch();
        idle(); Grb = 1; BAout = 1; Y_enable = 1; tick();
        idle(); c_select = 1; alu_instruction = 5'b00001; Z_enable = 1; tick();
        idle(); Z_LO_select = 1; Gra = 1; r_enable = 1; tick();
        chk("ldi_R3", R3_Data, 32'h00000065);
        chk("ldi_PC", PC_Data, 32'h1);
        chk("ldi_IR", IR_Data, 32'h09800065);

        // addi R2, R3, -5
        fetch();
        idle(); c_select = 1; Y_enable = 1; tick();
        idle(); Grb = 1; r_select = 1; alu_instruction = 5'b00011; Z_enable = 1; tick();
        idle(); Z_LO_select = 1; Gra = 1; r_enable = 1; tick();
        chk("addi_Y", Y_Data, 32'hFFFFFFFB);
        chk("addi_R2", R2_Data, 32'h00000060);

        // BAout forces 0 for R0, r_select does not.
        do_clear();
        load_const(32'd7);
        idle(); Grb = 1; BAout = 1; #1; chk("baout_r0", bus_Data, 32'h0); tick();
        idle(); Grb = 1; r_select = 1; #1; chk("rsel_r0", bus_Data, 32'h7); tick();

        // MUL: -2 * 3
        load_const(32'hFFFFFFFE);
        r0_to_mdr();
        load_const(32'd3);
        idle(); MDR_select = 1; Y_enable = 1; tick();
        idle(); Grb = 1; r_select = 1; alu_instruction = 5'b01100; Z_enable = 1; tick();
        chk("mul_hi", Z_HI_Data, 32'hFFFFFFFF);
        chk("mul_lo", Z_LO_Data, 32'hFFFFFFFA);

        // DIV: 7 / 2
        load_const(32'd7);
        r0_to_mdr();
        load_const(32'd2);
        idle(); MDR_select = 1; Y_enable = 1; tick();
        idle(); Grb = 1; r_select = 1; alu_instruction = 5'b01101; Z_enable = 1; tick();
        chk("div_lo", Z_LO_Data, 32'd3);
        chk("div_hi", Z_HI_Data, 32'd1);

        // Memory write then asynchronous read-back.
        load_const(32'd5);
        idle(); Grb = 1; r_select = 1; MAR_enable = 1; tick();
        load_const(32'hDEADBEEF);
        r0_to_mdr();
        idle(); write = 1; tick();
        idle(); read = 1; #1; chk("mem_rd", MDataIN, 32'hDEADBEEF); tick();

        // Divide by zero with Y holding DEADBEEF-derived data.
        idle(); MDR_select = 1; Y_enable = 1; tick();
        idle(); alu_instruction = 5'b01101; Z_enable = 1; tick();
        chk("div0_hi", Z_HI_Data, 32'h0);
        chk("div0_lo", Z_LO_Data, 32'h0);

        // Random T-states against the model.
        for (int n = 0; n < 400; n++) begin
            idle();
            PC_enable           = ($urandom_range(0, 5) == 0);
            PC_increment_enable = ($urandom_range(0, 3) == 0);
            IR_enable           = ($urandom_range(0, 3) == 0);
            Y_enable            = ($urandom_range(0, 2) == 0);
            Z_enable            = ($urandom_range(0, 2) == 0);
            MAR_enable          = ($urandom_range(0, 3) == 0);
            MDR_enable          = ($urandom_range(0, 2) == 0);
            r_enable            = ($urandom_range(0, 2) == 0);
            read                = ($urandom_range(0, 2) == 0);
            write               = ($urandom_range(0, 3) == 0);
            Gra                 = ($urandom_range(0, 2) == 0);
            Grb                 = ($urandom_range(0, 1) == 0);
            BAout               = ($urandom_range(0, 4) == 0);
            r_select            = ($urandom_range(0, 2) == 0);
            Z_LO_select         = ($urandom_range(0, 2) == 0);
            PC_select           = ($urandom_range(0, 2) == 0);
            MDR_select          = ($urandom_range(0, 2) == 0);
            c_select            = ($urandom_range(0, 1) == 0);
            alu_instruction     = 5'($urandom_range(0, 31));
            if ((r_select || BAout) && !(Gra || Grb)) Grb = 1;
            tick();
            if ($urandom_range(0, 99) == 0) do_clear();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
